// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the shift-add multiplier. Holds the
//               controller state encoding, the product-width helper and the
//               two's-complement magnitude function used at operand capture.
// Revision    : 1.0 - parametrised signed/unsigned multiplier
// ============================================================================
package mult_pkg;

    // Controller states. Encoding 2'b11 is unused; the FSM returns to IDLE
    // from it.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Working width of abs_w. Operands are sign- or zero-extended to this
    // width before the magnitude is taken, so one function serves every
    // WIDTH up to 32 (product width up to 64).
    localparam int c_ABS_W = 64;

    // Product width for a given operand width.
    function automatic int prodWidth(input int width);
        return 2 * width;
    endfunction

    // Magnitude of a two's-complement value held in c_ABS_W bits. A
    // non-negative (zero-extended) input is returned unchanged, which makes
    // the same path correct for unsigned operands.
    function automatic logic [c_ABS_W-1:0] abs_w(input logic [c_ABS_W-1:0] value);
        return value[c_ABS_W-1] ? ((~value) + 64'd1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mult_datapath
// Description : Datapath of the shift-add multiplier. Captures operand
//               magnitudes and the result sign, accumulates one multiplier
//               bit per strobe, and forms the signed/unsigned product.
//
// Ports       : clk              rising-edge clock
//               reset_n          asynchronous active-low reset
//               i_load           capture a/b/signedMode, clear accumulator
//               i_addShift       one multiply step (add if mplr[0], shift)
//               i_finish         register the (possibly negated) product
//               i_signedMode     1 = two's-complement operands
//               i_a, i_b         multiplicand / multiplier (WIDTH bits)
//               o_loadZero       multiplier magnitude at the inputs is zero
//               o_mplrNextZero   multiplier register is zero after this shift
//               o_product        registered product (2*WIDTH bits)
// Revision    : 1.0 - parametrised signed/unsigned multiplier
// ============================================================================
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic                 i_addShift,
    input  logic                 i_finish,
    input  logic                 i_signedMode,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_loadZero,
    output logic                 o_mplrNextZero,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int PW    = prodWidth(WIDTH);
    localparam int c_PAD = c_ABS_W - WIDTH;

    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic               r_neg;
    logic [PW-1:0]      r_product;

    logic [c_ABS_W-1:0] w_aExt;
    logic [c_ABS_W-1:0] w_bExt;
    logic [c_ABS_W-1:0] w_aAbsFull;
    logic [c_ABS_W-1:0] w_bAbsFull;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic               w_negLoad;
    logic [PW-1:0]      w_accSum;
    logic [PW-1:0]      w_result;
    logic               w_unusedAbsBits;

    // Operand capture: in unsigned mode the extension bits are zero so abs_w
    // leaves the value untouched. The magnitude of the most-negative value
    // (2^(WIDTH-1)) still fits in WIDTH unsigned bits.
    always_comb begin
        w_aExt     = {{c_PAD{i_signedMode & i_a[WIDTH-1]}}, i_a};
        w_bExt     = {{c_PAD{i_signedMode & i_b[WIDTH-1]}}, i_b};
        w_aAbsFull = abs_w(w_aExt);
        w_bAbsFull = abs_w(w_bExt);
        w_aMag     = w_aAbsFull[WIDTH-1:0];
        w_bMag     = w_bAbsFull[WIDTH-1:0];
        w_negLoad  = i_signedMode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end

    // Upper magnitude bits are always zero by construction.
    assign w_unusedAbsBits = ^{w_aAbsFull[c_ABS_W-1:WIDTH], w_bAbsFull[c_ABS_W-1:WIDTH]};

    // Accumulator add is PW bits wide; the sum of shifted magnitudes is
    // bounded by (2^WIDTH-1)^2 and cannot overflow.
    assign w_accSum = r_acc + r_mcand;

    // Negating a zero accumulator yields zero, so a zero product is always +0.
    assign w_result = r_neg ? ((~r_acc) + PW'(1)) : r_acc;

    assign o_loadZero     = (w_bMag == '0);
    assign o_mplrNextZero = (r_mplr[WIDTH-1:1] == '0);
    assign o_product      = r_product;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (i_load) begin
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_aMag};
            r_mplr    <= w_bMag;
            r_neg     <= w_negLoad;
        end else if (i_addShift) begin
            if (r_mplr[0]) begin
                r_acc <= w_accSum;
            end
            r_mcand   <= r_mcand << 1;
            r_mplr    <= r_mplr >> 1;
        end else if (i_finish) begin
            r_product <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential shift-add multiplier with run-time signed or
//               unsigned operands, early termination once the remaining
//               multiplier bits are zero, and a busy/done handshake.
//               Latency is k+1 cycles where k is the bit length of the
//               multiplier magnitude (1 cycle when b is zero).
//
// Ports       : clk          rising-edge clock
//               reset_n      asynchronous active-low reset
//               start        request, honoured only while busy is low
//               signed_mode  1 = two's-complement operands (sampled w/ start)
//               a            multiplicand, WIDTH bits (sampled with start)
//               b            multiplier, WIDTH bits (sampled with start)
//               busy         high while an operation is in flight
//               done         one-cycle pulse when product is updated
//               product      2*WIDTH-bit result, held until the next done
// Parameters  : WIDTH        operand width, 2..32
// Revision    : 1.0 - parametrised signed/unsigned multiplier
// ============================================================================
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;

    logic   w_load;
    logic   w_addShift;
    logic   w_finish;
    logic   w_loadZero;
    logic   w_mplrNextZero;

    // Datapath strobes are decoded from the registered state; start only
    // matters in IDLE, so a start while busy has no effect anywhere.
    always_comb begin
        w_load     = (r_state == IDLE) && start;
        w_addShift = (r_state == CALC);
        w_finish   = (r_state == FINISH);
    end

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_load         (w_load),
        .i_addShift     (w_addShift),
        .i_finish       (w_finish),
        .i_signedMode   (signed_mode),
        .i_a            (a),
        .i_b            (b),
        .o_loadZero     (w_loadZero),
        .o_mplrNextZero (w_mplrNextZero),
        .o_product      (product)
    );

    // Controller. busy and done are registered alongside the state so they
    // change on the same edges as the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        // A zero multiplier needs no add/shift steps.
                        r_state <= w_loadZero ? FINISH : CALC;
                    end
                end
                CALC: begin
                    if (w_mplrNextZero) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Self-checking bench for shift_add_multiplier (WIDTH=8).
//               Expected products come from plain integer arithmetic and
//               expected latency from the bit length of |b|.
// Revision    : 1.0
// ============================================================================
module tb_shift_add_multiplier;

    localparam int WIDTH = 8;
    localparam int PW    = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic            busy;
    logic            done;
    logic [PW-1:0]   product;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    // Reference: the true mathematical product truncated to 2*WIDTH bits.
    function automatic logic [PW-1:0] refProduct(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sm);
        int p;
        if (sm) p = int'($signed(x)) * int'($signed(y));
        else    p = int'(x) * int'(y);
        return p[PW-1:0];
    endfunction

    // Reference latency: bit length of the multiplier magnitude, plus one.
    function automatic int refLatency(input logic [WIDTH-1:0] y, input logic sm);
        int m;
        int k;
        m = sm ? int'($signed(y)) : int'(y);
        if (m < 0) m = -m;
        k = 0;
        while (m > 0) begin
            m = m / 2;
            k++;
        end
        return k + 1;
    endfunction

    // Issue one multiplication and follow it to done. repulseAt >= 1 drives a
    // competing 255x255 start that is sampled at edge E+repulseAt+... while
    // busy; tail checks the done pulse width and product hold afterwards.
    task automatic run_mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic sm, input int repulseAt, input bit tail,
                            input string tag);
        logic [PW-1:0] expP;
        logic [PW-1:0] oldP;
        int            expLat;
        int            lat;
        bit            seen;
        expP   = refProduct(x, y, sm);
        expLat = refLatency(y, sm);
        oldP   = product;
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
        total++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        else passed++;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= WIDTH + 4 && !seen; n++) begin
            if (n == repulseAt) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; signed_mode = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                total++;
                if (busy !== 1'b1) $display("FAIL %s busy_in_flight: cycle %0d got %b want 1", tag, n, busy);
                else passed++;
                total++;
                if (product !== oldP) $display("FAIL %s product_hold: cycle %0d got %h want %h", tag, n, product, oldP);
                else passed++;
            end
        end
        start = 1'b0;
        total++;
        if (!seen || lat != expLat) $display("FAIL %s latency: got %0d (seen=%0b) want %0d", tag, lat, seen, expLat);
        else passed++;
        total++;
        if (product !== expP) $display("FAIL %s product: got %h want %h", tag, product, expP);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        else passed++;
        if (tail) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) $display("FAIL %s done_width: got %b want 0", tag, done);
            else passed++;
            total++;
            if (product !== expP) $display("FAIL %s product_after_done: got %h want %h", tag, product, expP);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        total++;
        if (product !== 16'h0000) $display("FAIL reset_product: got %h want 0000", product);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_mult(8'd13,  8'd11,  1'b0, -1, 1'b1, "u13x11");
        run_mult(8'hF9,  8'h06,  1'b1, -1, 1'b1, "s-7x6");
        run_mult(8'h80,  8'h80,  1'b1, -1, 1'b1, "s-128x-128");
        run_mult(8'hFF,  8'hFF,  1'b0, -1, 1'b1, "u255x255");
        run_mult(8'd200, 8'h00,  1'b0, -1, 1'b1, "u200x0");
        run_mult(8'hFB,  8'h00,  1'b1, -1, 1'b1, "s-5x0");
        run_mult(8'h00,  8'hFD,  1'b1, -1, 1'b1, "s0x-3");
        run_mult(8'h7F,  8'h80,  1'b1, -1, 1'b1, "s127x-128");
    endtask

    task automatic test_busy_ignore();
        run_mult(8'd13, 8'd11, 1'b0, 2, 1'b1, "busy_ignore");
    endtask

    task automatic test_back_to_back();
        // First op returns on the done cycle so the next start is sampled
        // while done is high.
        run_mult(8'd13, 8'd11, 1'b0, -1, 1'b0, "b2b_first");
        run_mult(8'hF9, 8'h06, 1'b1, -1, 1'b1, "b2b_second");
    endtask

    task automatic test_async_reset();
        a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL async_reset_done: got %b want 0", done);
        else passed++;
        total++;
        if (product !== 16'h0000) $display("FAIL async_reset_product: got %h want 0000", product);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_mult(8'd3, 8'd3, 1'b0, -1, 1'b1, "after_reset_3x3");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             sm;
        for (int i = 0; i < 60; i++) begin
            x  = 8'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            sm = 1'($urandom);
            run_mult(x, y, sm, -1, 1'b1, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
